// File: rtl/sram_pkg.sv
// sram_pkg: shared widths and loader state encoding for the instruction SRAM write path
package sram_pkg;
  localparam int WORD_W         = 48;
  localparam int WORDS_PER_LINE = 5;
  localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
  localparam int ADDR_W         = 8;
  localparam int IDX_W          = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_WRITE, ST_DONE} loader_state_t;
endpackage

// File: rtl/sram_line_packer.sv
// sram_line_packer: shifts accepted words into a 240-bit line so word 0 lands in bits 47:0 once the line is full
module sram_line_packer
  import sram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_wr,
  input  logic [WORD_W-1:0] i_word,
  output logic [LINE_W-1:0] o_line,
  output logic              o_last
);
  logic [IDX_W-1:0]  r_idx;
  logic [LINE_W-1:0] r_line;
  assign o_last = r_idx == IDX_W'(WORDS_PER_LINE - 1);
  assign o_line = r_line;
  // word index within the current line; wraps after the last slot
  always_ff @(posedge clk)
    if (rst || i_clr) r_idx <= '0;
    else if (i_wr) r_idx <= o_last ? '0 : r_idx + 1'b1;
  // new words enter at the top slot and older ones shift down, so after five words the line is in order
  always_ff @(posedge clk)
    if (rst) r_line <= '0;
    else if (i_wr) r_line <= {i_word, r_line[LINE_W-1:WORD_W]};
endmodule

// File: rtl/i_sram_loader.sv
// i_sram_loader: streams 48-bit words into 240-bit SRAM lines at auto-incrementing addresses; checksum enabled by I_SRAM_LOADER_CHECKSUM_EN
module i_sram_loader
  import sram_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   line_count,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              WE,
  output logic [ADDR_W-1:0] WriteAddress,
  output logic [LINE_W-1:0] WriteBus,
  output logic              busy,
  output logic              done,
  output logic [15:0]       checksum
);
  loader_state_t     r_state;
  loader_state_t     w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic              w_start;
  logic              w_accept;
  logic              w_last;
  assign w_start      = r_state == ST_IDLE && start;
  assign w_accept     = r_state == ST_FILL && in_valid;
  assign in_ready     = r_state == ST_FILL;
  assign WE           = r_state == ST_WRITE;
  assign busy         = r_state != ST_IDLE;
  assign done         = r_state == ST_DONE;
  assign WriteAddress = r_addr;
  sram_line_packer u_packer (
    .clk    (clock),
    .rst    (reset),
    .i_clr  (w_start),
    .i_wr   (w_accept),
    .i_word (in_data),
    .o_line (WriteBus),
    .o_last (w_last)
  );
  // state register
  always_ff @(posedge clock)
    if (reset) r_state <= ST_IDLE;
    else r_state <= w_next;
  // next-state decode; a zero-line transfer skips straight to completion
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  w_next = w_start ? (line_count == '0 ? ST_DONE : ST_FILL) : ST_IDLE;
      ST_FILL:  w_next = w_accept && w_last ? ST_WRITE : ST_FILL;
      ST_WRITE: w_next = r_remaining == (ADDR_W + 1)'(1) ? ST_DONE : ST_FILL;
      ST_DONE:  w_next = ST_IDLE;
    endcase
  end
  // line address and lines-left counters, advanced once per written line
  always_ff @(posedge clock)
    if (reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (w_start) begin
      r_addr      <= base_addr;
      r_remaining <= line_count;
    end else if (r_state == ST_WRITE) begin
      r_addr      <= r_addr + 1'b1;
      r_remaining <= r_remaining - 1'b1;
    end
`ifdef I_SRAM_LOADER_CHECKSUM_EN
  logic [15:0] r_checksum;
  // XOR fold of each accepted word's three 16-bit lanes, cleared on every accepted start
  always_ff @(posedge clock)
    if (reset || w_start) r_checksum <= '0;
    else if (w_accept) r_checksum <= r_checksum ^ in_data[15:0] ^ in_data[31:16] ^ in_data[47:32];
  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_i_sram_loader.sv
// tb_i_sram_loader: directed table and sequence checks for the SRAM line loader
module tb_i_sram_loader;
  logic         clock = 0;
  logic         reset = 1;
  logic         start = 0;
  logic [7:0]   base_addr = 0;
  logic [8:0]   line_count = 0;
  logic         in_valid = 0;
  logic [47:0]  in_data = 0;
  logic         in_ready, WE, busy, done;
  logic [7:0]   WriteAddress;
  logic [239:0] WriteBus;
  logic [15:0]  checksum;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int rdy_we = 0;
  logic [7:0]   we_addr[$];
  logic [239:0] we_bus[$];
  int           we_cyc[$];

  i_sram_loader dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .line_count(line_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .WE(WE), .WriteAddress(WriteAddress), .WriteBus(WriteBus),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc++;
    if (WE) begin
      we_addr.push_back(WriteAddress);
      we_bus.push_back(WriteBus);
      we_cyc.push_back(cyc);
    end
    if (WE && in_ready) rdy_we++;
    if (done) done_cnt++;
  end

  typedef struct {
    logic        st;
    logic [7:0]  b;
    logic [8:0]  n;
    logic        v;
    logic [47:0] d;
    logic [3:0]  exp;
    logic        chk_addr;
    logic [7:0]  exp_addr;
  } vec_t;
  vec_t tv[8];

  task automatic check(input string name, input logic [239:0] act, input logic [239:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    we_addr.delete();
    we_bus.delete();
    we_cyc.delete();
    done_cnt = 0;
    rdy_we = 0;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] n);
    start = 1;
    base_addr = b;
    line_count = n;
    tick();
    start = 0;
  endtask

  task automatic send(input logic [47:0] w, input bit gaps);
    int t = 0;
    bit acc = 0;
    while (!acc && t < 50) begin
      if (gaps && $urandom_range(0, 1) == 0) begin
        in_valid = 0;
        tick();
      end
      in_valid = 1;
      in_data = w;
      acc = in_ready;
      tick();
      t++;
    end
    in_valid = 0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 100) begin
      tick();
      t++;
    end
    check("done_seen", done, 1);
  endtask

  function automatic logic [47:0] wd(input int l, input int j);
    return {16'(l), 16'hBEEF, 16'(j)};
  endfunction

  function automatic logic [239:0] line_of(input int l);
    logic [239:0] r;
    for (int j = 0; j < 5; j++) r[j*48 +: 48] = wd(l, j);
    return r;
  endfunction

  function automatic logic [239:0] ones_line();
    return {48'h5, 48'h4, 48'h3, 48'h2, 48'h1};
  endfunction

  initial begin
    logic [15:0] exp_ck;
    tv[0] = '{1'b1, 8'h10, 9'd1, 1'b0, 48'h0, 4'b1010, 1'b0, 8'h00};
    for (int i = 1; i < 5; i++) tv[i] = '{1'b0, 8'h00, 9'd0, 1'b1, 48'(i), 4'b1010, 1'b0, 8'h00};
    tv[5] = '{1'b0, 8'h00, 9'd0, 1'b1, 48'h5, 4'b0110, 1'b1, 8'h10};
    tv[6] = '{1'b0, 8'h00, 9'd0, 1'b0, 48'h0, 4'b0011, 1'b0, 8'h00};
    tv[7] = '{1'b0, 8'h00, 9'd0, 1'b0, 48'h0, 4'b0000, 1'b0, 8'h00};

    repeat (3) tick();
    check("reset_ctrl", {in_ready, WE, busy, done}, 0);
    check("reset_addr", WriteAddress, 0);
    check("reset_bus", WriteBus, 0);
    check("reset_ck", checksum, 0);
    reset = 0;
    tick();
    clear_log();

    for (int i = 0; i < 8; i++) begin
      start = tv[i].st;
      base_addr = tv[i].b;
      line_count = tv[i].n;
      in_valid = tv[i].v;
      in_data = tv[i].d;
      tick();
      check($sformatf("vec%0d_ctrl", i), {in_ready, WE, busy, done}, tv[i].exp);
      if (tv[i].chk_addr) begin
        check($sformatf("vec%0d_addr", i), WriteAddress, tv[i].exp_addr);
        check($sformatf("vec%0d_bus", i), WriteBus, ones_line());
      end
    end
    start = 0;
    in_valid = 0;
`ifdef I_SRAM_LOADER_CHECKSUM_EN
    exp_ck = 16'h0001;
`else
    exp_ck = 16'h0000;
`endif
    check("t1_checksum", checksum, exp_ck);
    check("t1_we_count", we_addr.size(), 1);
    check("t1_done_count", done_cnt, 1);

    clear_log();
    do_start(8'hFE, 9'd3);
    for (int l = 0; l < 3; l++)
      for (int j = 0; j < 5; j++) send(wd(l, j), 0);
    wait_done();
    tick();
    check("t2_we_count", we_addr.size(), 3);
    if (we_addr.size() == 3) begin
      check("t2_addr0", we_addr[0], 8'hFE);
      check("t2_addr1", we_addr[1], 8'hFF);
      check("t2_addr2", we_addr[2], 8'h00);
      for (int l = 0; l < 3; l++) check($sformatf("t2_bus%0d", l), we_bus[l], line_of(l));
      check("t2_gap01", we_cyc[1] - we_cyc[0], 6);
      check("t2_gap12", we_cyc[2] - we_cyc[1], 6);
    end
    check("t2_idle", busy, 0);

    clear_log();
    do_start(8'h10, 9'd1);
    for (int j = 1; j <= 5; j++) send(48'(j), 1);
    wait_done();
    tick();
    check("t3_we_count", we_addr.size(), 1);
    if (we_addr.size() == 1) begin
      check("t3_addr", we_addr[0], 8'h10);
      check("t3_bus", we_bus[0], ones_line());
    end
    check("t3_ready_in_write", rdy_we, 0);

    clear_log();
    do_start(8'h55, 9'd0);
    check("t4_zero_done", {WE, busy, done}, 3'b011);
    tick();
    check("t4_zero_idle", {busy, done}, 2'b00);
    check("t4_zero_we", we_addr.size(), 0);
    do_start(8'h40, 9'd2);
    for (int j = 0; j < 3; j++) send(wd(0, j), 0);
    do_start(8'h80, 9'd5);
    for (int j = 3; j < 5; j++) send(wd(0, j), 0);
    for (int j = 0; j < 5; j++) send(wd(1, j), 0);
    wait_done();
    tick();
    check("t4_busy_we_count", we_addr.size(), 2);
    if (we_addr.size() == 2) begin
      check("t4_addr0", we_addr[0], 8'h40);
      check("t4_addr1", we_addr[1], 8'h41);
      check("t4_bus0", we_bus[0], line_of(0));
    end
    check("t4_idle", busy, 0);

    clear_log();
    do_start(8'h20, 9'd3);
    for (int j = 0; j < 5; j++) send(wd(0, j), 0);
    for (int j = 0; j < 3; j++) send(wd(1, j), 0);
    reset = 1;
    tick();
    check("t5_rst_ctrl", {in_ready, WE, busy, done}, 0);
    check("t5_rst_addr", WriteAddress, 0);
    check("t5_rst_bus", WriteBus, 0);
    check("t5_rst_ck", checksum, 0);
    reset = 0;
    repeat (8) tick();
    check("t5_we_count", we_addr.size(), 1);
    check("t5_no_done", done_cnt, 0);
    clear_log();
    do_start(8'h30, 9'd1);
    send(48'h000100020003, 0);
    send(48'h000400050006, 0);
    for (int j = 0; j < 3; j++) send(48'h0, 0);
    wait_done();
`ifdef I_SRAM_LOADER_CHECKSUM_EN
    exp_ck = 16'h0007;
`else
    exp_ck = 16'h0000;
`endif
    check("t6_ck_done", checksum, exp_ck);
    repeat (3) tick();
    check("t6_ck_stable", checksum, exp_ck);
    check("t5_new_we_count", we_addr.size(), 1);
    if (we_addr.size() == 1) begin
      check("t5_new_addr", we_addr[0], 8'h30);
      check("t5_new_bus", we_bus[0], {48'h0, 48'h0, 48'h0, 48'h000400050006, 48'h000100020003});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
